paralelo_serial_tx: RTL and testbench
=====================================

# paralelo_serial_tx

Byte-to-serial transmitter sitting directly upstream of the PHY serial-to-parallel receiver. It accepts bytes through a valid/ready handshake into a small FIFO and serializes them MSB-first on `clk_32f`. Every 8-cycle byte slot with no data carries the comma/idle byte. After reset it sends a fixed run of commas so the downstream receiver can lock and raise its active flag.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; power of 2, ≥2.
- `SYNC_COMMAS`, 4: comma bytes sent after reset before data may go out; ≥4, as the receiver needs 4 consecutive commas.
- `COMMA`, 8'hBC: idle/sync byte.
- `clk_32f` in 1: bit clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high. Clock is `clk_32f`.
- `data_in` in 8: byte to transmit.
- `valid_in` in 1: `data_in` is valid.
- `ready_out` out 1: FIFO can accept; `= (count != FIFO_DEPTH)`, driven from registered count.
- `data_out` out 1: registered serial bit stream.
- `active_out` out 1: high once sync commas are complete (state RUN).
- `fifo_count` out clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Reset values:
  - `data_out`=0, `active_out`=0, `fifo_count`=0, `ready_out`=1.
  - `bit_cnt`=0, `cur_byte`=COMMA, `sync_cnt`=0, state=SYNC.
  - FIFO pointers cleared; FIFO contents are don't-care.
- Serializer, every non-reset edge:
  - `data_out <= cur_byte[7-bit_cnt]`; `bit_cnt <= bit_cnt+1` (3 bits, wraps 7→0).
- Byte boundary is the edge where `bit_cnt==7`. On that edge `cur_byte` loads the next byte:
  - SYNC: load COMMA; `sync_cnt++`. When `sync_cnt == SYNC_COMMAS-1`, go to RUN. The byte loaded on that edge is still COMMA, giving SYNC_COMMAS+1 leading commas including the reset-loaded one.
  - RUN, FIFO non-empty: pop the head into `cur_byte`.
  - RUN, FIFO empty: load COMMA.
- Push: on an edge with `valid_in && ready_out`, write `data_in` at the write pointer.
  - Pushes are accepted in SYNC and are held until RUN.
- Occupancy on the same edge: push+pop keeps count unchanged; push only → +1; pop only → −1.
- Boundary cases:
  - Full: `ready_out`=0, so no push, even if a pop occurs on the same edge. `ready_out` rises the edge after the pop.
  - Empty at a boundary: no bypass. A byte pushed on the boundary edge is not popped that edge; COMMA is sent and the byte goes in the next slot.
  - Data bytes equal to COMMA are sent unmodified; upstream owns that ambiguity.
  - Pointers wrap modulo FIFO_DEPTH.
  - `reset` mid-byte aborts the byte, flushes the FIFO and restarts the SYNC sequence on the next edge.
- `active_out` = (state==RUN), registered.

## Timing
- Edge n = nth rising edge after the reset-deassert edge (n=1 is the first edge with reset low).
- Byte k (k=0 is the reset-loaded COMMA) occupies `data_out` after edges 8k+1…8k+8, MSB first.
- With SYNC_COMMAS=4:
  - Bytes 0–4 are COMMA.
  - `active_out` rises after edge 32.
  - Byte 5 (bits after edges 41–48) is the first slot that can carry data.
- Latency, byte pushed while FIFO empty in RUN: its MSB appears after the first boundary edge strictly later than the push edge, plus 1. Minimum 2 edges, maximum 9.
- Throughput: 1 byte / 8 clocks; steady-state ready whenever the producer rate is ≤ that.

## Test plan
- Reset release, no `valid_in`: `data_out` repeats 1,0,1,1,1,1,0,0 forever. `active_out` 0→1 after edge 32. `ready_out`=1 throughout.
- Push 0xA5 on edge 2 (during SYNC): slots 0–4 are 0xBC, slot 5 is 1,0,1,0,0,1,0,1, then 0xBC again. `fifo_count` goes 1 → 0 at edge 40.
- Push 0x01,0x02,0x03,0x04 on consecutive edges during SYNC:
  - `fifo_count`=4 and `ready_out`=0, and a 5th push of 0x05 is refused.
  - Slots 5–8 carry 01,02,03,04.
  - `ready_out`=1 the edge after the edge-40 pop.
- In RUN with FIFO empty, push 0x3C exactly on a boundary edge: that slot is COMMA and 0x3C is in the following slot.
- Assert `reset` for 1 cycle mid-byte with 3 bytes queued:
  - All outputs return to their reset values.
  - Queued bytes are never transmitted.
  - 5 commas precede any new data; `active_out` is low again until edge 32.
- Loopback into the downstream receiver (shared reset, `clk_4f`=`clk_32f`/8, phase-aligned to the boundary): receiver `active_to_PS` asserts during sync. Bytes 0x11,0x22,0x33 reach `data2send_to_LDMX` in order with `valid_out_to_LDMX`=1 for those bytes only.

Source files
------------

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: valid/ready byte FIFO feeding an MSB-first
// serializer on clk_32f, with a post-reset comma run for receiver lock.
module paralelo_serial_tx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_COMMAS = 4,
  parameter logic [7:0]  COMMA       = 8'hBC
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          data_out,
  output logic                          active_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SYNC_COMMAS);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COMMAS - 1);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    cur_byte_q, cur_byte_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic          data_q, data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic boundary, push, pop;

  assign ready_out  = (count_q != FULL_CNT);
  assign data_out   = data_q;
  assign active_out = (state_q == ST_RUN);
  assign fifo_count = count_q;

  always_comb begin
    boundary   = (bit_cnt_q == 3'd7);
    push       = valid_in && ready_out;
    // Pop only looks at the registered count, so a byte pushed on the
    // boundary edge itself waits for the next slot.
    pop        = boundary && (state_q == ST_RUN) && (count_q != '0);

    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    cur_byte_d = cur_byte_q;
    data_d     = cur_byte_q[3'd7 - bit_cnt_q];
    bit_cnt_d  = bit_cnt_q + 3'd1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (boundary) begin
      case (state_q)
        ST_SYNC: begin
          cur_byte_d = COMMA;
          sync_cnt_d = sync_cnt_q + SW'(1);
          if (sync_cnt_q == SYNC_LAST) state_d = ST_RUN;
        end
        default: cur_byte_d = pop ? mem_q[rd_ptr_q] : COMMA;
      endcase
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      sync_cnt_q <= '0;
      cur_byte_q <= COMMA;
      data_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      cur_byte_q <= cur_byte_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage has no reset; pointers define what is valid.
  always_ff @(posedge clk_32f) begin
    if (push && !reset) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: directed steps plus random traffic checked
// edge by edge against a slot-level queue model.
module tb_paralelo_serial_tx;

  localparam int         DEPTH = 4;
  localparam int         SYNC  = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        ready_out, data_out, active_out;
  logic [2:0]  fifo_count;

  paralelo_serial_tx #(.FIFO_DEPTH(DEPTH), .SYNC_COMMAS(SYNC), .COMMA(COMMA)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .active_out(active_out),
    .fifo_count(fifo_count)
  );

  always #5 clk_32f = ~clk_32f;

  int          errors = 0;
  int          checks = 0;
  int          n = 0;
  logic [7:0]  m_cur = COMMA;
  logic [7:0]  mq[$];
  logic [7:0]  slot_log[$];
  logic [7:0]  rx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    int   p;
    logic pre_ready;
    logic exp_data;
    reset = r; valid_in = v; data_in = d;
    @(posedge clk_32f);
    if (r) begin
      n = 0; mq.delete(); slot_log.delete(); m_cur = COMMA; exp_data = 1'b0;
    end else begin
      p = n % 8;
      exp_data = m_cur[7-p];
      pre_ready = (mq.size() < DEPTH);
      if (p == 7) begin
        // Next slot index n/8+1; data may occupy slots SYNC+1 onwards.
        if ((n/8 + 1) >= SYNC + 1 && mq.size() > 0) m_cur = mq.pop_front();
        else m_cur = COMMA;
      end
      if (v && pre_ready) mq.push_back(d);
      n++;
    end
    #1;
    chk("data_out",   32'(data_out),   32'(exp_data));
    chk("active_out", 32'(active_out), (!r && n >= 8*SYNC) ? 32'd1 : 32'd0);
    chk("ready_out",  32'(ready_out),  (mq.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    if (!r) begin
      rx = {rx[6:0], data_out};
      if (n % 8 == 0) slot_log.push_back(rx);
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk_slot(input string tag, input int k, input logic [7:0] exp);
    logic [7:0] got;
    got = (slot_log.size() > k) ? slot_log[k] : 8'hxx;
    chk(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [7:0] got[$];

    // Reset state and idle comma stream
    do_reset();
    run_to(64);
    for (int k = 0; k < 8; k++) chk_slot("idle_slot", k, COMMA);

    // Single byte pushed during SYNC
    do_reset();
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'hA5);
    run_to(39);
    chk("a5_count_pre", 32'(fifo_count), 32'd1);
    run_to(40);
    chk("a5_count_pop", 32'(fifo_count), 32'd0);
    run_to(56);
    for (int k = 0; k < 5; k++) chk_slot("a5_lead", k, COMMA);
    chk_slot("a5_slot5", 5, 8'hA5);
    chk_slot("a5_slot6", 6, COMMA);

    // Fill to full, refused 5th push, then boundary push with empty FIFO
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1'b0, 1'b1, 8'(i));
    chk("full_ready", 32'(ready_out), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    tick(1'b0, 1'b1, 8'h05);
    chk("refused_count", 32'(fifo_count), 32'd4);
    run_to(39);
    chk("ready_before_pop", 32'(ready_out), 32'd0);
    run_to(40);
    chk("ready_after_pop", 32'(ready_out), 32'd1);
    run_to(79);
    tick(1'b0, 1'b1, 8'h3C);
    run_to(96);
    for (int k = 0; k < 4; k++) chk_slot("full_slots", 5 + k, 8'(k + 1));
    chk_slot("refused_absent", 9, COMMA);
    chk_slot("boundary_comma", 10, COMMA);
    chk_slot("boundary_byte", 11, 8'h3C);

    // Mid-byte reset with bytes queued flushes everything
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    run_to(21);
    tick(1'b1, 1'b0, 8'h00);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_active", 32'(active_out), 32'd0);
    run_to(31);
    chk("resync_active_lo", 32'(active_out), 32'd0);
    run_to(64);
    for (int k = 0; k < 8; k++) chk_slot("flush_slot", k, COMMA);

    // Loopback-style byte order check
    do_reset();
    run_to(2);
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h22);
    tick(1'b0, 1'b1, 8'h33);
    run_to(96);
    for (int k = 5; k < slot_log.size(); k++)
      if (slot_log[k] != COMMA) got.push_back(slot_log[k]);
    chk("lb_count", 32'(got.size()), 32'd3);
    chk("lb_b0", 32'((got.size() > 0) ? got[0] : 8'hxx), 32'h11);
    chk("lb_b1", 32'((got.size() > 1) ? got[1] : 8'hxx), 32'h22);
    chk("lb_b2", 32'((got.size() > 2) ? got[2] : 8'hxx), 32'h33);

    // Random traffic, including bursts that hit full
    do_reset();
    for (int i = 0; i < 800; i++)
      tick(1'b0, ($urandom_range(0, 7) < ((i / 100) % 2 == 0 ? 1 : 5)), 8'($urandom_range(0, 255)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
